muldiv_sequencer: RTL

Controller between the control unit and the multi-cycle multiplier/divider pair that share the HI/LO registers. It accepts one MULT or DIV request at a time, latches the operands, issues the single-cycle start pulse to the selected engine, and waits for ready with a timeout. It then writes both HI and LO in one cycle, or raises a divide-by-zero or timeout event. It also interlocks MFHI/MFLO reads, stalling them while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/cycle_timer.sv | 37 +++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer and its cycle timer.
// The state encoding is owned here so later sequencers can reuse it.
package muldiv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
      WB,
      DZ
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/cycle_timer.sv
// Clearable up-counter that flags the last allowed wait cycle (TIMEOUT-1).
// It holds at the expiry value so an over-long enable cannot wrap back to zero.
module cycle_timer
   import muldiv_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TW-1:0] count_reg, count_next;

   assign expired = (count_reg == TW'(TIMEOUT - 1));

   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (en && !expired) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV at a time onto the shared multiplier/divider engines,
// writes HI/LO together, and interlocks MFHI/MFLO while an op is in flight.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int TW      = $clog2(TIMEOUT + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        op_div,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        op_ready,
   output logic [31:0] eng_a,
   output logic [31:0] eng_b,
   output logic        mult_start,
   output logic        div_start,
   input  logic        mult_ready,
   input  logic        div_ready,
   input  logic [31:0] eng_hi,
   input  logic [31:0] eng_lo,
   output logic        hi_wr,
   output logic        lo_wr,
   output logic [31:0] hi_data,
   output logic [31:0] lo_data,
   input  logic        rd_req,
   output logic        rd_stall,
   output logic        busy,
   output logic        div_zero,
   output logic        timeout,
   input  logic        flush
);

   state_t      state_reg, state_next;
   logic        op_div_reg;
   logic [31:0] a_reg, b_reg, hi_reg, lo_reg;
   logic        accept, capture, timer_clr, timer_en, expired, active_ready;

   // Only the engine that was started may end the wait.
   assign active_ready = (op_div_reg == OP_DIV) ? div_ready : mult_ready;

   cycle_timer #(
      .TIMEOUT(TIMEOUT),
      .TW     (TW)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clr    (timer_clr),
      .en     (timer_en),
      .expired(expired)
   );

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      capture    = 1'b0;
      timer_clr  = 1'b0;
      timer_en   = 1'b0;
      mult_start = 1'b0;
      div_start  = 1'b0;
      hi_wr      = 1'b0;
      lo_wr      = 1'b0;
      div_zero   = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (op_valid && !flush) begin
               accept     = 1'b1;
               state_next = (op_div == OP_DIV && rt_val == '0) ? DZ : START;
            end
         end
         START: begin
            mult_start = !flush && (op_div_reg == OP_MULT);
            div_start  = !flush && (op_div_reg == OP_DIV);
            timer_clr  = 1'b1;
            state_next = RUN;
         end
         RUN: begin
            if (active_ready) begin
               capture    = !flush;
               state_next = WB;
            end else if (expired) begin
               timeout    = !flush;
               state_next = IDLE;
            end else begin
               timer_en = 1'b1;
            end
         end
         WB: begin
            hi_wr      = !flush;
            lo_wr      = !flush;
            state_next = IDLE;
         end
         DZ: begin
            div_zero   = !flush;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         op_div_reg <= OP_MULT;
         a_reg      <= '0;
         b_reg      <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_div_reg <= op_div;
            a_reg      <= rs_val;
            b_reg      <= rt_val;
         end
         if (capture) begin
            hi_reg <= eng_hi;
            lo_reg <= eng_lo;
         end
      end
   end

   // A read in the accept cycle precedes the op in program order, so it is not held.
   assign busy     = (state_reg != IDLE);
   assign rd_stall = rd_req && busy;
   assign op_ready = (state_reg == IDLE) && !flush;
   assign eng_a    = a_reg;
   assign eng_b    = b_reg;
   assign hi_data  = hi_reg;
   assign lo_data  = lo_reg;

endmodule
